// File: rtl/note_recorder_pkg.sv
// ============================================================================
// note_recorder_pkg : shared note codes, LED patterns, recorder states
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package note_recorder_pkg;

  localparam logic [3:0] NOTE_C5   = 4'd0;
  localparam logic [3:0] NOTE_B    = 4'd1;
  localparam logic [3:0] NOTE_A    = 4'd2;
  localparam logic [3:0] NOTE_G    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_D    = 4'd6;
  localparam logic [3:0] NOTE_C4   = 4'd7;
  localparam logic [3:0] NOTE_NONE = 4'd8;

  // One-hot LED patterns, C4 on the lowest LED
  localparam logic [7:0] _C5 = 8'h80;
  localparam logic [7:0] _B  = 8'h40;
  localparam logic [7:0] _A  = 8'h20;
  localparam logic [7:0] _G  = 8'h10;
  localparam logic [7:0] _F  = 8'h08;
  localparam logic [7:0] _E  = 8'h04;
  localparam logic [7:0] _D  = 8'h02;
  localparam logic [7:0] _C4 = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } rec_state_t;

  function automatic logic [3:0] sanitize_note(input logic [3:0] code);
    return (code > NOTE_NONE) ? NOTE_NONE : code;
  endfunction

  function automatic logic [7:0] led_decode(input logic [3:0] code);
    logic [7:0] pattern;
    case (code)
      NOTE_C5:   pattern = _C5;
      NOTE_B:    pattern = _B;
      NOTE_A:    pattern = _A;
      NOTE_G:    pattern = _G;
      NOTE_F:    pattern = _F;
      NOTE_E:    pattern = _E;
      NOTE_D:    pattern = _D;
      NOTE_C4:   pattern = _C4;
      NOTE_NONE: pattern = 8'h00;
      default:   pattern = 8'hFF;
    endcase
    return pattern;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_ram.sv
// ============================================================================
// note_ram : DEPTH x 4 note buffer, one write port, asynchronous read port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module note_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  // Storage is deliberately not reset; validity is tracked by the length count
  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/note_recorder.sv
// ============================================================================
// note_recorder : records the keyboard note stream per beat tick, replays it
// Build option: LOOP_PLAYBACK_EN - playback wraps to entry 0 instead of ending
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          BEAT_TICK,
  input  logic          REC_START,
  input  logic          PLAY_START,
  input  logic          STOP,
  input  logic [3:0]    KEY_NOTE,
  output logic [3:0]    note,
  output logic [7:0]    Led,
  output logic          rec_active,
  output logic          play_active,
  output logic [AW:0]   length
);

  localparam logic [AW:0] LEN_LAST = (AW+1)'(DEPTH - 1);

  rec_state_t  state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  // One extra bit so the pointer can sit at length == DEPTH after the last entry
  logic [AW:0]   rd_ptr, rd_ptr_n;
  logic [AW:0]   length_n;
  logic [3:0]    note_n;
  logic          ram_we;
  logic [3:0]    ram_wdata;
  logic [3:0]    ram_rdata;

  assign ram_wdata = sanitize_note(KEY_NOTE);

  note_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_note_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      length <= '0;
      note   <= NOTE_NONE;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      length <= length_n;
      note   <= note_n;
    end
  end

  // Commands take priority over and swallow a coincident beat tick
  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    length_n = length;
    note_n   = note;
    ram_we   = 1'b0;
    if (STOP) begin
      state_n = IDLE;
      note_n  = NOTE_NONE;
    end else if (REC_START) begin
      state_n  = RECORD;
      wr_ptr_n = '0;
      length_n = '0;
      note_n   = NOTE_NONE;
    end else if (PLAY_START) begin
      if (length != '0) begin
        state_n  = PLAY;
        rd_ptr_n = '0;
        note_n   = NOTE_NONE;
      end
    end else if (BEAT_TICK) begin
      case (state)
        RECORD: begin
          ram_we   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          length_n = length + 1'b1;
          note_n   = ram_wdata;
          if (length == LEN_LAST) state_n = IDLE;
        end
        PLAY: begin
`ifdef LOOP_PLAYBACK_EN
          note_n   = ram_rdata;
          rd_ptr_n = (rd_ptr + 1'b1 == length) ? '0 : rd_ptr + 1'b1;
`else
          if (rd_ptr == length) begin
            state_n = IDLE;
            note_n  = NOTE_NONE;
          end else begin
            note_n   = ram_rdata;
            rd_ptr_n = rd_ptr + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign Led         = led_decode(note);
  assign rec_active  = (state == RECORD);
  assign play_active = (state == PLAY);

endmodule

`default_nettype wire
